// File: rtl/movavg_arb_if.sv
// Requester, datapath and result signals of the movavg_arb scheduler.
// slave is the scheduler's view; master is the requester/datapath side.
interface movavg_arb_if;
    logic        req0_valid;
    logic [63:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [63:0] req1_data;
    logic        req1_ready;
    logic [63:0] dp_din;
    logic [63:0] dp_dout;
    logic        res_valid;
    logic        res_id;
    logic [63:0] res_data;
    logic        abort_valid;
    logic        abort_id;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, dp_dout,
        output req0_ready, req1_ready, dp_din,
        output res_valid, res_id, res_data, abort_valid, abort_id
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, dp_dout,
        input  req0_ready, req1_ready, dp_din,
        input  res_valid, res_id, res_data, abort_valid, abort_id
    );
endinterface

// File: rtl/movavg_arb.sv
// Round-robin scheduler sharing one movavg moving-sum datapath between two
// burst requesters; tags each window through the pipeline and returns its sum.
module movavg_arb #(
    parameter int unsigned TAPS    = 4,
    parameter int unsigned LATENCY = 4
) (
    input logic         clk,
    input logic         reset,
    movavg_arb_if.slave bus
);
    localparam int unsigned CntW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(TAPS - 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                push_tag, abort_set;
    logic                owner_valid, other_valid, beat_fire, winner;
    logic [63:0]         owner_data;
    logic [LATENCY-1:0]  tag_vld_q, tag_id_q;
    logic                res_valid_q, res_id_q;
    logic [63:0]         res_data_q;
    logic                abort_valid_q, abort_id_q;

    always_comb begin
        owner_valid = owner_q ? bus.req1_valid : bus.req0_valid;
        other_valid = owner_q ? bus.req0_valid : bus.req1_valid;
        owner_data  = owner_q ? bus.req1_data : bus.req0_data;
        beat_fire   = (state_q == StBurst) && owner_valid;
        // On a tie the requester not last served wins; a lone requester always wins.
        winner      = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        push_tag  = 1'b0;
        abort_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    state_d = StBurst;
                    owner_d = winner;
                    cnt_d   = '0;
                end
            end
            StBurst: begin
                if (!owner_valid) begin
                    abort_set = 1'b1;
                    last_d    = owner_q;
                    state_d   = StIdle;
                end else if (cnt_q == LastBeat) begin
                    push_tag = 1'b1;
                    last_d   = owner_q;
                    cnt_d    = '0;
                    // The owner's valid this cycle is its own last beat, so only
                    // the other requester can be handed the datapath without a bubble.
                    if (other_valid) begin
                        owner_d = ~owner_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_comb begin
        bus.req0_ready  = (state_q == StBurst) && !owner_q;
        bus.req1_ready  = (state_q == StBurst) && owner_q;
        bus.dp_din      = beat_fire ? owner_data : '0;
        bus.res_valid   = res_valid_q;
        bus.res_id      = res_id_q;
        bus.res_data    = res_data_q;
        bus.abort_valid = abort_valid_q;
        bus.abort_id    = abort_id_q;
    end

    // Stage k holds a window whose last beat was LATENCY-k cycles before the
    // datapath presents its sum at the final stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= push_tag;
            tag_id_q[0]  <= owner_q;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid_q   <= 1'b0;
            res_id_q      <= 1'b0;
            res_data_q    <= '0;
            abort_valid_q <= 1'b0;
            abort_id_q    <= 1'b0;
        end else begin
            res_valid_q   <= tag_vld_q[LATENCY-1];
            abort_valid_q <= abort_set;
            if (tag_vld_q[LATENCY-1]) begin
                res_id_q   <= tag_id_q[LATENCY-1];
                res_data_q <= bus.dp_dout;
            end
            if (abort_set) begin
                abort_id_q <= owner_q;
            end
        end
    end

    ready_onehot_a: assert property (@(posedge clk) disable iff (!reset)
        !(bus.req0_ready && bus.req1_ready));

endmodule

// File: tb/tb_movavg_arb.sv
// Scoreboard bench for movavg_arb with a behavioural 4-tap, latency-4 datapath.
module tb_movavg_arb;
    localparam int unsigned TAPS    = 4;
    localparam int unsigned LATENCY = 4;

    typedef struct packed {
        logic        vld;
        logic [63:0] d;
    } beat_t;

    typedef struct packed {
        logic        id;
        logic [63:0] data;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    movavg_arb_if bus ();

    movavg_arb #(
        .TAPS    (TAPS),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in datapath: window ending in cycle t appears on dout in cycle t+4.
    logic [63:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;
    logic [63:0] p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clk) begin
        h0 <= bus.dp_din;
        h1 <= h0;
        h2 <= h1;
        h3 <= h2;
        p1 <= h0 + h1 + h2 + h3;
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.dp_dout = p3;

    int   n_cmp  = 0;
    int   n_fail = 0;
    beat_t q0[$], q1[$];
    res_t  exp_res[$];
    logic  exp_abort[$];
    int    res_cyc[$];
    int    grant_log[$];
    int    abort_cyc = -1;
    res_t  mon_e;
    logic  mon_a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Requester drivers: a head beat is held until accepted; a vld=0 entry is a
    // one-cycle valid-low gap.
    logic f0, f1;
    bit   pres0 = 0, pres1 = 0;
    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        forever begin
            @(negedge clk);
            f0 = bus.req0_valid & bus.req0_ready;
            f1 = bus.req1_valid & bus.req1_ready;
            @(posedge clk);
            #1;
            if (flush) begin
                q0.delete();
                q1.delete();
                pres0 = 0;
                pres1 = 0;
            end
            if (pres0 && (f0 || !q0[0].vld)) void'(q0.pop_front());
            if (pres1 && (f1 || !q1[0].vld)) void'(q1.pop_front());
            if (q0.size() > 0) begin
                bus.req0_valid = q0[0].vld;
                bus.req0_data  = q0[0].d;
                pres0 = 1;
            end else begin
                bus.req0_valid = 1'b0;
                bus.req0_data  = '0;
                pres0 = 0;
            end
            if (q1.size() > 0) begin
                bus.req1_valid = q1[0].vld;
                bus.req1_data  = q1[0].d;
                pres1 = 1;
            end else begin
                bus.req1_valid = 1'b0;
                bus.req1_data  = '0;
                pres1 = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a result or abort.
    logic prev_r0 = 1'b0, prev_r1 = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.res_valid) begin
                res_cyc.push_back(cyc);
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_res: got id=%0d data=%h, required no result (cycle %0d)",
                             bus.res_id, bus.res_data, cyc);
                end else begin
                    mon_e = exp_res.pop_front();
                    check("res_id", 64'(bus.res_id), 64'(mon_e.id));
                    check("res_data", bus.res_data, mon_e.data);
                end
            end
            if (bus.abort_valid) begin
                abort_cyc = cyc;
                if (exp_abort.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_abort: got id=%0d, required no abort (cycle %0d)",
                             bus.abort_id, cyc);
                end else begin
                    mon_a = exp_abort.pop_front();
                    check("abort_id", 64'(bus.abort_id), 64'(mon_a));
                end
            end
            if (bus.req0_ready && !prev_r0) grant_log.push_back(0);
            if (bus.req1_ready && !prev_r1) grant_log.push_back(1);
            prev_r0 = bus.req0_ready;
            prev_r1 = bus.req1_ready;
        end
    end

    task automatic push_burst(input int id, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [63:0] d);
        beat_t bt;
        logic [63:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            bt.vld = 1'b1;
            bt.d   = v[i];
            if (id == 0) q0.push_back(bt);
            else         q1.push_back(bt);
        end
    endtask

    task automatic expect_res(input logic id, input logic [63:0] data);
        res_t e;
        e.id   = id;
        e.data = data;
        exp_res.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_res.size() > 0 || exp_abort.size() > 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s: %0d results and %0d aborts still pending, required 0",
                     name, exp_res.size(), exp_abort.size());
            exp_res.delete();
            exp_abort.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req0_ready"}, 64'(bus.req0_ready), 64'(0));
        check({tag, "_req1_ready"}, 64'(bus.req1_ready), 64'(0));
        check({tag, "_dp_din"}, bus.dp_din, 64'(0));
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'(0));
        check({tag, "_res_id"}, 64'(bus.res_id), 64'(0));
        check({tag, "_res_data"}, bus.res_data, 64'(0));
        check({tag, "_abort_valid"}, 64'(bus.abort_valid), 64'(0));
        check({tag, "_abort_id"}, 64'(bus.abort_id), 64'(0));
    endtask

    initial begin
        int c;
        int g;
        int fires;
        beat_t gap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;

        // Simultaneous request straight after reset: req0 first, req1 with no bubble.
        @(posedge clk); #2;
        res_cyc.delete();
        push_burst(0, 1, 1, 1, 1);
        push_burst(1, 2, 2, 2, 2);
        expect_res(1'b0, 64'd4);
        expect_res(1'b1, 64'd8);
        wait_idle("simul", 60);
        check("simul_count", 64'(res_cyc.size()), 64'(2));
        if (res_cyc.size() == 2) check("simul_spacing", 64'(res_cyc[1] - res_cyc[0]), 64'(4));

        // Single burst from idle: result exactly 9 cycles after the request.
        @(posedge clk); #2;
        res_cyc.delete();
        push_burst(0, 1, 2, 3, 4);
        expect_res(1'b0, 64'hA);
        g = 0;
        while (!bus.req0_valid && g < 10) begin
            @(negedge clk);
            g++;
        end
        c = cyc;
        if (g >= 10) timeout_fail("single_req");
        wait_idle("single", 40);
        check("single_count", 64'(res_cyc.size()), 64'(1));
        if (res_cyc.size() == 1) check("single_latency", 64'(res_cyc[0] - c), 64'(9));

        // Modulo 2^64 wrap.
        @(posedge clk); #2;
        push_burst(1, '1, '1, '1, '1);
        expect_res(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_idle("wrap", 40);

        // Fairness: both hold valid for three bursts each.
        @(posedge clk); #2;
        grant_log.delete();
        for (int k = 0; k < 3; k++) begin
            push_burst(0, 64'h100 + k, 64'h100 + k, 64'h100 + k, 64'h100 + k);
            push_burst(1, 64'h200 + k, 64'h200 + k, 64'h200 + k, 64'h200 + k);
            expect_res(1'b0, 64'h400 + 4 * k);
            expect_res(1'b1, 64'h800 + 4 * k);
        end
        wait_idle("fair", 120);
        check("fair_grants", 64'(grant_log.size()), 64'(6));
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            check("fair_grant_order", 64'(grant_log[i]), 64'(i % 2));

        // Abort: req1 drops valid on beat 2, then req0 bursts 5,6,7,8.
        @(posedge clk); #2;
        q1.push_back(beat_t'{vld: 1'b1, d: 64'h11});
        q1.push_back(beat_t'{vld: 1'b1, d: 64'h22});
        gap.vld = 1'b0;
        gap.d   = '0;
        q1.push_back(gap);
        exp_abort.push_back(1'b1);
        expect_res(1'b0, 64'h1A);
        g = 0;
        while (!(bus.req1_valid && bus.req1_ready) && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (g >= 10) timeout_fail("abort_first_beat");
        push_burst(0, 5, 6, 7, 8);
        g = 0;
        while (!(bus.req1_ready && !bus.req1_valid) && g < 10) begin
            @(negedge clk);
            g++;
        end
        c = cyc;
        if (g >= 10) timeout_fail("abort_gap");
        wait_idle("abort", 60);
        check("abort_delay", 64'(abort_cyc - c), 64'(1));

        // Reset during req0 beat 1 while req1's result is still in flight.
        @(posedge clk); #2;
        push_burst(1, 1, 1, 1, 1);
        push_burst(0, 9, 9, 9, 9);
        fires = 0;
        g = 0;
        while (fires < 2 && g < 40) begin
            @(negedge clk);
            g++;
            if (bus.req0_valid && bus.req0_ready) fires++;
        end
        if (fires < 2) timeout_fail("midreset_beat1");
        reset = 1'b0;
        flush = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b1;
        flush = 1'b0;
        repeat (15) @(negedge clk);
        @(posedge clk); #2;
        push_burst(0, 64'h10, 64'h20, 64'h30, 64'h40);
        expect_res(1'b0, 64'hA0);
        wait_idle("post_reset", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
